// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter letting two CPU instruction caches share
// one RAM read port. The data side (dbusy) holds off new grants, but a fetch
// that is already in progress always runs to completion.
module imem_arbiter #(
  parameter bit FIRST_CPU = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  iREN,
  input  logic [31:0] iaddr0,
  input  logic [31:0] iaddr1,
  input  logic        dbusy,
  output logic [1:0]  iwait,
  output logic [31:0] iload0,
  output logic [31:0] iload1,
  output logic        ramREN,
  output logic [31:0] ramaddr,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  grant
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t state_q, state_d;
  logic   g_q, g_d;        // CPU that owns the current transaction
  logic   last_q, last_d;  // CPU that most recently received a word
  logic   pick;

  // Only a lone requester wins outright. When both CPUs request, the CPU
  // that was not served last wins.
  assign pick = (iREN == 2'b11) ? ~last_q : iREN[1];

  // Next-state and output decode. The RAM is never addressed during an IDLE
  // cycle, so each grant costs one cycle of latency.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    iwait   = 2'b11;
    iload0  = '0;
    iload1  = '0;
    ramREN  = 1'b0;
    ramaddr = '0;
    grant   = 2'b00;
    case (state_q)
      IDLE: begin
        if (!dbusy && (iREN != 2'b00)) begin
          g_d     = pick;
          state_d = SERVE;
        end
      end
      SERVE: begin
        grant   = g_q ? 2'b10 : 2'b01;
        ramaddr = g_q ? iaddr1 : iaddr0;
        if (!iREN[g_q]) begin
          // The owner dropped its request. Release the RAM and keep last_q
          // unchanged, because no word was delivered.
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          // FREE, BUSY and ERROR all leave the fetch in SERVE, so an ERROR
          // response just retries the same read.
          if (ramstate == RAM_ACCESS) begin
            iwait[g_q] = 1'b0;
            if (g_q) iload1 = ramload;
            else     iload0 = ramload;
            last_d  = g_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      g_q     <= FIRST_CPU;
      last_q  <= ~FIRST_CPU;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter. On each falling edge the driver applies inputs,
// works out the expected outputs from a transaction-level model, and pushes
// them onto queues. The monitor samples the DUT 3ns later and pops the queues
// to compare.
module tb_imem_arbiter;
  localparam bit FIRST = 1'b0;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  iREN;
  logic [31:0] iaddr0, iaddr1, ramload;
  logic        dbusy;
  logic [1:0]  ramstate;
  logic [1:0]  iwait, grant;
  logic [31:0] iload0, iload1, ramaddr;
  logic        ramREN;

  imem_arbiter #(.FIRST_CPU(FIRST)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .dbusy(dbusy), .iwait(iwait), .iload0(iload0), .iload1(iload1),
    .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload),
    .ramstate(ramstate), .grant(grant)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  iwait;
    logic [31:0] l0, l1;
    logic        ren;
    logic [31:0] addr;
    logic [1:0]  grant;
  } exp_t;
  typedef struct {
    int          cpu;
    logic [31:0] d;
  } dlv_t;

  exp_t eq[$];
  dlv_t dq[$];
  int   n_cmp = 0, n_bad = 0;
  bit   done  = 0;

  // Model state: the CPU being served (-1 when nobody is being served) and
  // the CPU that received the most recent word.
  int own  = -1;
  int last = 1 - int'(FIRST);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Run one clock cycle: apply the inputs, predict the outputs, then advance
  // the model to the state that follows the next rising edge.
  task automatic cyc(input logic rn, input logic [1:0] ren, input logic db,
                     input logic [1:0] rs, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [31:0] rl);
    exp_t e;
    bit   dlv;
    @(negedge CLK);
    nRST = rn; iREN = ren; dbusy = db; ramstate = rs;
    iaddr0 = a0; iaddr1 = a1; ramload = rl;
    e.iwait = 2'b11; e.l0 = 0; e.l1 = 0; e.ren = 0; e.addr = 0; e.grant = 0;
    dlv = 0;
    if (own >= 0) begin
      e.grant = 2'(1 << own);
      e.addr  = (own == 1) ? a1 : a0;
      e.ren   = ren[own];
      dlv     = ren[own] && (rs == ACC);
      if (dlv) begin
        e.iwait[own] = 1'b0;
        if (own == 1) e.l1 = rl; else e.l0 = rl;
        dq.push_back('{own, rl});
      end
    end
    eq.push_back(e);
    if (!rn) begin
      own  = -1;
      last = 1 - int'(FIRST);
    end else if (own < 0) begin
      if (!db && ren != 2'b00)
        own = (ren == 2'b11) ? 1 - last : ((ren == 2'b10) ? 1 : 0);
    end else if (!ren[own]) begin
      own = -1;
    end else if (dlv) begin
      last = own;
      own  = -1;
    end
  endtask

  task automatic rcyc(input logic rn, input logic [1:0] ren, input logic db, input logic [1:0] rs);
    cyc(rn, ren, db, rs, $urandom, $urandom, $urandom);
  endtask

  // Monitor: compare every cycle that has an expectation queued, and pop a
  // delivery record whenever the DUT delivers a word to a CPU.
  initial begin
    exp_t e;
    dlv_t d;
    forever begin
      @(negedge CLK);
      #3;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("iwait",   32'(iwait),  32'(e.iwait));
        chk("iload0",  iload0,      e.l0);
        chk("iload1",  iload1,      e.l1);
        chk("ramREN",  32'(ramREN), 32'(e.ren));
        chk("ramaddr", ramaddr,     e.addr);
        chk("grant",   32'(grant),  32'(e.grant));
        for (int c = 0; c < 2; c++) begin
          if (iwait[c] === 1'b0) begin
            if (dq.size() == 0) begin
              chk("unexpected_delivery_cpu", 32'(c), 32'hFFFF_FFFF);
            end else begin
              d = dq.pop_front();
              chk("delivery_cpu",  32'(c), 32'(d.cpu));
              chk("delivery_data", (c == 1) ? iload1 : iload0, d.d);
            end
          end
        end
      end
      if (done && eq.size() == 0) break;
    end
  end

  initial begin
    nRST = 0; iREN = 0; dbusy = 0; ramstate = FREE;
    iaddr0 = 0; iaddr1 = 0; ramload = 0;
    // Let the state registers load before any output is checked.
    repeat (2) @(posedge CLK);
    // Outputs while held in reset
    repeat (3) rcyc(0, 2'b00, 0, FREE);

    // Single fetch: CPU0 at 0x100, ACCESS on the third SERVE cycle
    cyc(1, 2'b01, 0, FREE,   32'h100, 32'h0, 32'h0);
    cyc(1, 2'b01, 0, FREE,   32'h100, 32'h0, 32'h0);
    cyc(1, 2'b01, 0, BUSY,   32'h100, 32'h0, 32'h0);
    cyc(1, 2'b01, 0, ACC,    32'h100, 32'h0, 32'hDEADBEEF);
    cyc(1, 2'b00, 0, FREE,   32'h100, 32'h0, 32'h0);

    // Contention straight after reset: strict alternation starting at CPU0
    rcyc(0, 2'b11, 0, ACC);
    repeat (10) rcyc(1, 2'b11, 0, ACC);

    // dbusy holds off CPU1 for 5 cycles, then CPU1 is served
    repeat (5) rcyc(1, 2'b10, 1, ACC);
    rcyc(1, 2'b10, 0, BUSY);
    rcyc(1, 2'b10, 1, BUSY);   // dbusy rising during SERVE must not abort
    rcyc(1, 2'b10, 1, ACC);

    // Withdraw: CPU0 in SERVE on BUSY, then drops the request
    rcyc(0, 2'b00, 0, FREE);
    rcyc(1, 2'b01, 0, FREE);
    rcyc(1, 2'b01, 0, BUSY);
    rcyc(1, 2'b00, 0, BUSY);
    repeat (5) rcyc(1, 2'b11, 0, ACC);

    // Error retry: 4 ERROR cycles, then ACCESS, one delivery
    rcyc(1, 2'b10, 0, FREE);
    repeat (4) rcyc(1, 2'b10, 0, ERR);
    rcyc(1, 2'b10, 0, ACC);
    rcyc(1, 2'b00, 0, ACC);

    // Reset asserted mid-transaction
    rcyc(1, 2'b11, 0, BUSY);
    rcyc(1, 2'b11, 0, BUSY);
    rcyc(0, 2'b11, 0, ACC);
    rcyc(1, 2'b11, 0, ACC);
    rcyc(1, 2'b11, 0, ACC);

    // Random traffic; each CPU tends to hold its request across cycles
    begin
      logic [1:0] ren = 2'b00;
      for (int i = 0; i < 3000; i++) begin
        for (int c = 0; c < 2; c++)
          if ($urandom_range(0, 3) == 0) ren[c] = ~ren[c];
        rcyc(($urandom_range(0, 99) != 0), ren, ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)));
      end
    end
    rcyc(1, 2'b00, 0, FREE);
    done = 1;
    repeat (3) @(posedge CLK);
    chk("pending_expectations", 32'(eq.size()), 32'd0);
    chk("pending_deliveries",   32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
